uart_reg_scheduler: RTL and testbench

- Controller that sequences the simpleuart register interface (reg_dat_*/reg_div_*) and shares its transmitter between N byte requesters.
- Programs the baud divider once after reset, continuously polls the receive register into a small FIFO, and round-robin arbitrates requesters onto the write port with a stall watchdog.
- Sits between simpleuart and application logic (LED command decoders, echo/status senders).

---
 rtl/uart_reg_scheduler_pkg.sv | 23 ++
 rtl/uart_reg_scheduler_if.sv | 42 ++++
 rtl/uart_reg_scheduler_arb.sv | 58 +++++
 rtl/uart_reg_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_uart_reg_scheduler.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_reg_scheduler_pkg.sv
// uart_sched_pkg: shared types and constants for the simpleuart register
// scheduler.
//   tx_state_e   : transmit sequencer states
//   UART_NO_DATA : value simpleuart returns on reg_dat_do when no byte waits
//   BYTE_W       : width of one UART byte
//   byte_to_word : zero-extends a byte onto the 32-bit register bus
package uart_sched_pkg;

  typedef enum logic [1:0] {
    TX_INIT    = 2'd0,
    TX_IDLE    = 2'd1,
    TX_WRITE   = 2'd2,
    TX_RELEASE = 2'd3
  } tx_state_e;

  localparam logic [31:0] UART_NO_DATA = 32'hFFFF_FFFF;
  localparam int          BYTE_W       = 8;

  function automatic logic [31:0] byte_to_word(input logic [BYTE_W-1:0] b);
    return {24'h00_0000, b};
  endfunction

endpackage

// File: rtl/uart_reg_scheduler_if.sv
// uart_reg_scheduler_if: every non-clock signal of the scheduler.
//   UART side      : reg_div_we/di, reg_dat_we/re/di (to UART), reg_dat_do/wait (from UART)
//   requester side : tx_req/tx_data (in), tx_gnt/tx_err (out)
//   consumer side  : rx_valid/rx_data/rx_count (out), rx_ready (in)
//   status         : ready (out)
// modport master is the scheduler; modport slave is the surrounding system.
interface uart_reg_scheduler_if #(
  parameter int N_REQ    = 2,
  parameter int RX_DEPTH = 4
);
  localparam int CNT_W = $clog2(RX_DEPTH) + 1;

  logic                 reg_div_we;
  logic [31:0]          reg_div_di;
  logic                 reg_dat_we;
  logic                 reg_dat_re;
  logic [31:0]          reg_dat_di;
  logic [31:0]          reg_dat_do;
  logic                 reg_dat_wait;
  logic [N_REQ-1:0]     tx_req;
  logic [8*N_REQ-1:0]   tx_data;
  logic [N_REQ-1:0]     tx_gnt;
  logic                 tx_err;
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic                 rx_ready;
  logic [CNT_W-1:0]     rx_count;
  logic                 ready;

  modport master (
    output reg_div_we, reg_div_di, reg_dat_we, reg_dat_re, reg_dat_di,
    output tx_gnt, tx_err, rx_valid, rx_data, rx_count, ready,
    input  reg_dat_do, reg_dat_wait, tx_req, tx_data, rx_ready
  );

  modport slave (
    input  reg_div_we, reg_div_di, reg_dat_we, reg_dat_re, reg_dat_di,
    input  tx_gnt, tx_err, rx_valid, rx_data, rx_count, ready,
    output reg_dat_do, reg_dat_wait, tx_req, tx_data, rx_ready
  );

endinterface

// File: rtl/uart_reg_scheduler_arb.sv
// rr_arbiter: round-robin requester selection.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : request vector
//   advance_i     : move the priority pointer to one past the current winner
//   grant_o       : one-hot winner (zero when nothing requests)
//   index_o       : binary index of the winner
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  input  logic             advance_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] index_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [N_REQ-1:0] grant_s;
  logic [IDX_W-1:0] index_s;

  // Scan requesters starting at the pointer; the first one found wins.
  always_comb begin
    int   cand;
    logic found;
    grant_s = '0;
    index_s = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_q) + k;
      cand = (cand >= N_REQ) ? cand - N_REQ : cand;
      if (!found && req_i[IDX_W'(cand)]) begin
        found                   = 1'b1;
        grant_s[IDX_W'(cand)]   = 1'b1;
        index_s                 = IDX_W'(cand);
      end else begin
        found = found;
      end
    end
  end

  // Priority pointer: after a winner is retired, it becomes lowest priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= (index_s == IDX_W'(N_REQ - 1)) ? '0 : index_s + IDX_W'(1);
    end else begin
      ptr_q <= ptr_q;
    end
  end

  assign grant_o = grant_s;
  assign index_o = index_s;

endmodule

// File: rtl/uart_reg_scheduler.sv
// uart_reg_scheduler: sequences the simpleuart register interface.
//   clk, resetn : clock shared with simpleuart, asynchronous active-low reset
//   bus         : uart_reg_scheduler_if.master (UART registers, requesters,
//                 RX consumer, ready)
// Writes the baud divider once after reset, polls the receive register into a
// small FIFO, and round-robin shares the UART transmitter between requesters
// with a watchdog on reg_dat_wait.
module uart_reg_scheduler #(
  parameter int N_REQ      = 2,
  parameter int INIT_DIV   = 625,
  parameter int RX_DEPTH   = 4,
  parameter int TX_TIMEOUT = 16384
) (
  input logic               clk,
  input logic               resetn,
  uart_reg_scheduler_if.master bus
);
  import uart_sched_pkg::*;

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TX_TIMEOUT + 1);

  // ---------------- TX sequencer ----------------
  tx_state_e        state_q;
  logic             div_we_q;
  logic [31:0]      div_di_q;
  logic             ready_q;
  logic             we_q;
  logic [31:0]      di_q;
  logic [N_REQ-1:0] gnt_q;
  logic             err_q;
  logic [IDX_W-1:0] idx_q;
  logic [TO_W-1:0]  wait_cnt_q;

  logic [N_REQ-1:0]  arb_req_s;
  logic [N_REQ-1:0]  arb_grant_s;
  logic [IDX_W-1:0]  arb_idx_s;
  logic [BYTE_W-1:0] sel_byte_s;
  logic              accept_s;
  logic              timeout_s;
  logic              advance_s;

  // Outside IDLE the arbiter only sees the latched requester, so its index
  // matches idx_q when the pointer advances even if tx_req has changed.
  always_comb begin
    arb_req_s = '0;
    if (state_q == TX_IDLE) begin
      arb_req_s = bus.tx_req;
    end else begin
      arb_req_s[idx_q] = 1'b1;
    end
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk_i     (clk),
    .rst_ni    (resetn),
    .req_i     (arb_req_s),
    .advance_i (advance_s),
    .grant_o   (arb_grant_s),
    .index_o   (arb_idx_s)
  );

  assign sel_byte_s = bus.tx_data[{arb_idx_s, 3'b000} +: BYTE_W];
  assign accept_s   = (state_q == TX_WRITE) && we_q && !bus.reg_dat_wait;
  assign timeout_s  = (state_q == TX_WRITE) && we_q && bus.reg_dat_wait &&
                      (wait_cnt_q == TO_W'(TX_TIMEOUT - 1));
  assign advance_s  = accept_s || timeout_s;

  // TX state machine with all of its outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= TX_INIT;
      div_we_q   <= 1'b0;
      div_di_q   <= 32'd0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      di_q       <= 32'd0;
      gnt_q      <= '0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wait_cnt_q <= '0;
    end else begin
      div_we_q <= 1'b0;
      gnt_q    <= '0;
      err_q    <= 1'b0;
      case (state_q)
        TX_INIT: begin
          // div_we_q distinguishes the strobe cycle from the cycle after it.
          if (!div_we_q) begin
            div_we_q <= 1'b1;
            div_di_q <= 32'(INIT_DIV);
          end else begin
            div_di_q <= 32'd0;
            ready_q  <= 1'b1;
            state_q  <= TX_IDLE;
          end
        end
        TX_IDLE: begin
          if (|bus.tx_req) begin
            idx_q      <= arb_idx_s;
            di_q       <= byte_to_word(sel_byte_s);
            we_q       <= 1'b1;
            wait_cnt_q <= '0;
            state_q    <= TX_WRITE;
          end else begin
            state_q <= TX_IDLE;
          end
        end
        TX_WRITE: begin
          if (accept_s) begin
            we_q    <= 1'b0;
            gnt_q   <= arb_grant_s;
            state_q <= TX_RELEASE;
          end else if (timeout_s) begin
            we_q    <= 1'b0;
            err_q   <= 1'b1;
            state_q <= TX_RELEASE;
          end else begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
          end
        end
        TX_RELEASE: begin
          // One cycle with we low so the UART never sees a held strobe twice.
          state_q <= TX_IDLE;
        end
        default: begin
          we_q    <= 1'b0;
          state_q <= TX_INIT;
        end
      endcase
    end
  end

  // ---------------- RX poller and FIFO ----------------
  logic [BYTE_W-1:0] mem_q [RX_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              re_q;
  logic              rx_valid_q;
  logic [BYTE_W-1:0] rx_data_q;

  logic              pop_s;
  logic              push_s;
  logic [CNT_W-1:0]  remain_s;
  logic [CNT_W-1:0]  cnt_d;
  logic [PTR_W-1:0]  rd_ptr_d;
  logic [BYTE_W-1:0] rx_head_d;

  // Poll/push decision and next head. A pop in the same cycle frees a slot,
  // so a full FIFO can still accept. While re is high the UART has not yet
  // cleared its buffer, so the same byte must not be taken again.
  always_comb begin
    pop_s    = rx_valid_q && bus.rx_ready;
    push_s   = ready_q && !re_q && (bus.reg_dat_do != UART_NO_DATA) &&
               ((cnt_q < CNT_W'(RX_DEPTH)) || pop_s);
    remain_s = cnt_q - CNT_W'(pop_s);
    cnt_d    = remain_s + CNT_W'(push_s);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
    if (remain_s == '0) begin
      rx_head_d = bus.reg_dat_do[BYTE_W-1:0];
    end else begin
      rx_head_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO storage, pointers, occupancy, registered head and read strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < RX_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      re_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= bus.reg_dat_do[BYTE_W-1:0];
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      re_q       <= push_s;
      rx_valid_q <= (cnt_d != '0);
      rx_data_q  <= (cnt_d != '0) ? rx_head_d : rx_data_q;
    end
  end

  assign bus.reg_div_we = div_we_q;
  assign bus.reg_div_di = div_di_q;
  assign bus.reg_dat_we = we_q;
  assign bus.reg_dat_re = re_q;
  assign bus.reg_dat_di = di_q;
  assign bus.tx_gnt     = gnt_q;
  assign bus.tx_err     = err_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_count   = cnt_q;
  assign bus.ready      = ready_q;

endmodule

// File: tb/tb_uart_reg_scheduler.sv
// Directed bench for uart_reg_scheduler with a behavioural simpleuart model
// and scoreboards for received and transmitted bytes.
module tb_uart_reg_scheduler;

  localparam int NR    = 2;
  localparam int DEPTH = 4;
  localparam int TMO   = 128;
  localparam int DIV   = 625;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  uart_reg_scheduler_if #(.N_REQ(NR), .RX_DEPTH(DEPTH)) bif ();

  uart_reg_scheduler #(
    .N_REQ(NR), .INIT_DIV(DIV), .RX_DEPTH(DEPTH), .TX_TIMEOUT(TMO)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bif.master)
  );

  int passed = 0;
  int total  = 0;

  logic [7:0] src_q[$];      // bytes the UART model will present
  logic [7:0] rx_exp_q[$];   // bytes expected out of the FIFO, in order
  logic [7:0] tx_exp_b[$];   // bytes expected on the UART write port
  int         tx_exp_i[$];   // requester expected to be granted for each
  int         re_pulses = 0;
  int         we_cycles = 0;
  int         err_seen  = 0;
  bit         gnt_pending = 1'b0;
  int         gnt_idx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // simpleuart receive side: strobe consumes the presented byte.
  always @(negedge clk) begin
    if (bif.reg_dat_re === 1'b1) begin
      re_pulses++;
      if (src_q.size() != 0) void'(src_q.pop_front());
    end
    if (src_q.size() != 0) bif.reg_dat_do = {24'h0, src_q[0]};
    else                   bif.reg_dat_do = 32'hFFFF_FFFF;
  end

  // TX scoreboard: accepted writes and the grant that must follow each one.
  always @(negedge clk) begin
    if (bif.reg_dat_we === 1'b1) we_cycles++;
    if (bif.tx_err === 1'b1) err_seen++;
    if (gnt_pending) begin
      chk("tx_gnt", 32'(bif.tx_gnt), 32'(1 << gnt_idx));
      gnt_pending = 1'b0;
    end else if (bif.tx_gnt !== '0) begin
      chk("tx_gnt_spurious", 32'(bif.tx_gnt), 32'd0);
    end
    if (bif.reg_dat_we === 1'b1 && bif.reg_dat_wait === 1'b0) begin
      if (tx_exp_b.size() == 0) begin
        chk("tx_unexpected_write", 32'(bif.reg_dat_we), 32'd0);
      end else begin
        chk("tx_byte", bif.reg_dat_di, {24'h0, tx_exp_b.pop_front()});
        gnt_idx     = tx_exp_i.pop_front();
        gnt_pending = 1'b1;
      end
    end
  end

  // RX scoreboard: every pop must deliver the next expected byte.
  always @(negedge clk) begin
    if (bif.rx_valid === 1'b1 && bif.rx_ready === 1'b1) begin
      if (rx_exp_q.size() == 0) chk("rx_unexpected_pop", 32'(bif.rx_valid), 32'd0);
      else                      chk("rx_byte", 32'(bif.rx_data), 32'(rx_exp_q.pop_front()));
    end
  end

  // Called right after resetn rises (posedge+1): divider strobe then ready.
  task automatic check_init(input string tag);
    int          div_cycles = 0;
    int          div_at     = -1;
    int          first_rdy  = -1;
    int          early      = 0;
    logic [31:0] div_val    = 32'd0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bif.reg_div_we === 1'b1) begin
        div_cycles++;
        div_at  = c;
        div_val = bif.reg_div_di;
      end
      if (bif.ready === 1'b1 && first_rdy < 0) first_rdy = c;
      if (bif.ready !== 1'b1 && (bif.reg_dat_re === 1'b1 || bif.reg_dat_we === 1'b1)) early++;
    end
    chk({tag, "_div_we_cycles"}, 32'(div_cycles), 32'd1);
    chk({tag, "_div_di"}, div_val, 32'(DIV));
    chk({tag, "_ready_latency"}, 32'(first_rdy), 32'(div_at + 1));
    chk({tag, "_no_access_before_ready"}, 32'(early), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int r0;
    int w0;
    int held;
    resetn           = 1'b0;
    bif.tx_req       = '0;
    bif.tx_data      = '0;
    bif.reg_dat_wait = 1'b0;
    bif.rx_ready     = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_div_we", 32'(bif.reg_div_we), 32'd0);
    chk("rst_div_di", bif.reg_div_di, 32'd0);
    chk("rst_ready", 32'(bif.ready), 32'd0);
    chk("rst_dat_we", 32'(bif.reg_dat_we), 32'd0);
    chk("rst_dat_re", 32'(bif.reg_dat_re), 32'd0);
    chk("rst_rx_valid", 32'(bif.rx_valid), 32'd0);
    chk("rst_rx_count", 32'(bif.rx_count), 32'd0);
    chk("rst_tx_gnt", 32'(bif.tx_gnt), 32'd0);

    resetn = 1'b1;
    check_init("init");

    // Single received byte
    r0 = re_pulses;
    src_q.push_back(8'h31);
    rx_exp_q.push_back(8'h31);
    n = 0;
    while (bif.rx_valid !== 1'b1 && n < 20) begin tick(); n++; end
    chk("rx1_valid", 32'(bif.rx_valid), 32'd1);
    chk("rx1_data", 32'(bif.rx_data), 32'h31);
    chk("rx1_count", 32'(bif.rx_count), 32'd1);
    tick(); tick();
    chk("rx1_re_pulses", 32'(re_pulses - r0), 32'd1);
    bif.rx_ready = 1'b1;
    tick();
    bif.rx_ready = 1'b0;
    chk("rx1_count_after_pop", 32'(bif.rx_count), 32'd0);
    chk("rx1_valid_after_pop", 32'(bif.rx_valid), 32'd0);

    // Two requesters at once, no stall: strict rotation starting at 0
    w0 = we_cycles;
    tx_exp_b.push_back(8'hA5); tx_exp_i.push_back(0);
    tx_exp_b.push_back(8'h5A); tx_exp_i.push_back(1);
    bif.tx_data = 16'h5AA5;
    bif.tx_req  = 2'b11;
    n = 0;
    while (bif.tx_req != 2'b00 && n < 30) begin
      tick(); n++;
      bif.tx_req = bif.tx_req & ~bif.tx_gnt;
    end
    chk("rr_all_served", 32'(bif.tx_req), 32'd0);
    tick(); tick();
    chk("rr_we_cycles", 32'(we_cycles - w0), 32'd2);
    chk("rr_tx_queue_drained", 32'(tx_exp_b.size()), 32'd0);

    // Stall for 100 cycles, then release: byte accepted when wait drops
    bif.reg_dat_wait = 1'b1;
    bif.tx_data      = 16'h003C;
    tx_exp_b.push_back(8'h3C); tx_exp_i.push_back(0);
    bif.tx_req = 2'b01;
    n = 0;
    while (bif.reg_dat_we !== 1'b1 && n < 10) begin tick(); n++; end
    chk("stall_we_rise", 32'(bif.reg_dat_we), 32'd1);
    held = 0;
    repeat (100) begin
      tick();
      if (bif.reg_dat_we === 1'b1) held++;
    end
    chk("stall_we_held", 32'(held), 32'd100);
    chk("stall_no_gnt", 32'(bif.tx_gnt), 32'd0);
    bif.reg_dat_wait = 1'b0;
    tick();
    chk("stall_gnt", 32'(bif.tx_gnt), 32'd1);
    chk("stall_we_low", 32'(bif.reg_dat_we), 32'd0);
    bif.tx_req = 2'b00;
    tick(); tick();

    // Wait stuck high: watchdog abort after TMO cycles, no grant
    bif.reg_dat_wait = 1'b1;
    bif.tx_data      = 16'hC300;
    bif.tx_req       = 2'b10;
    n = 0;
    while (bif.reg_dat_we !== 1'b1 && n < 10) begin tick(); n++; end
    chk("tmo_we_rise", 32'(bif.reg_dat_we), 32'd1);
    n = 0;
    while (bif.tx_err !== 1'b1 && n < 3 * TMO) begin tick(); n++; end
    chk("tmo_err_cycle", 32'(n), 32'(TMO));
    chk("tmo_no_gnt", 32'(bif.tx_gnt), 32'd0);
    chk("tmo_we_low", 32'(bif.reg_dat_we), 32'd0);
    bif.tx_req       = 2'b00;
    bif.reg_dat_wait = 1'b0;
    repeat (5) tick();

    // Five bytes with no consumer: FIFO saturates at DEPTH
    r0 = re_pulses;
    for (int i = 0; i < 5; i++) begin
      src_q.push_back(8'(8'h10 + i));
      rx_exp_q.push_back(8'(8'h10 + i));
    end
    repeat (30) tick();
    chk("full_count", 32'(bif.rx_count), 32'(DEPTH));
    chk("full_re_pulses", 32'(re_pulses - r0), 32'(DEPTH));
    chk("full_head", 32'(bif.rx_data), 32'h10);
    bif.rx_ready = 1'b1;
    tick();
    bif.rx_ready = 1'b0;
    repeat (10) tick();
    chk("refill_count", 32'(bif.rx_count), 32'(DEPTH));
    chk("refill_re_pulses", 32'(re_pulses - r0), 32'd5);
    chk("refill_head", 32'(bif.rx_data), 32'h11);
    bif.rx_ready = 1'b1;
    n = 0;
    while (bif.rx_count != '0 && n < 20) begin tick(); n++; end
    bif.rx_ready = 1'b0;
    chk("drain_count", 32'(bif.rx_count), 32'd0);
    chk("drain_rx_queue_empty", 32'(rx_exp_q.size()), 32'd0);

    // Reset in the middle of a stalled write, with a byte held in the FIFO
    src_q.push_back(8'h55);
    n = 0;
    while (bif.rx_valid !== 1'b1 && n < 20) begin tick(); n++; end
    chk("mid_rst_rx_loaded", 32'(bif.rx_count), 32'd1);
    bif.reg_dat_wait = 1'b1;
    bif.tx_data      = 16'h0077;
    bif.tx_req       = 2'b01;
    n = 0;
    while (bif.reg_dat_we !== 1'b1 && n < 10) begin tick(); n++; end
    chk("mid_rst_we_rise", 32'(bif.reg_dat_we), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_we_drop", 32'(bif.reg_dat_we), 32'd0);
    chk("mid_rst_rx_count", 32'(bif.rx_count), 32'd0);
    chk("mid_rst_rx_valid", 32'(bif.rx_valid), 32'd0);
    chk("mid_rst_ready", 32'(bif.ready), 32'd0);
    bif.tx_req       = 2'b00;
    bif.reg_dat_wait = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    check_init("reinit");
    repeat (3) tick();

    chk("end_tx_queue_empty", 32'(tx_exp_b.size()), 32'd0);
    chk("end_err_pulses", 32'(err_seen), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
